ov5642_pwr_seq: RTL
===================

OV5642_PWR_SEQ -- requirements
Module: ov5642_pwr_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, the i_clk frequency in Hz.
REQ-002 SHALL have parameter T_PWR_US, default 5000, the supply-settle time in us, with PWDN held high.
REQ-003 SHALL have parameter T_RST_US, default 1000, the time in us from PWDN low to RESETB high.
REQ-004 SHALL have parameter T_SCCB_US, default 20000, the time in us from RESETB high to the SCCB init start.
REQ-005 SHALL have parameter T_INIT_TO_US, default 500000, the maximum time in us to wait for the init result.
REQ-006 SHALL have parameter MAX_RETRY, default 2, the number of full re-sequences allowed after an init failure.
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-008 SHALL have port i_rst_n, input, 1 bit: reset; one clock; reset is asynchronous and active-low.
REQ-009 SHALL have port i_restart, input, 1 bit: one-cycle pulse that re-runs the full sequence.
REQ-010 SHALL have port i_init_done, input, 1 bit: level from sccb_top, table written and verified.
REQ-011 SHALL have port i_init_err, input, 1 bit: level from sccb_top, init failed.
REQ-012 SHALL have port o_pwdn, output, 1 bit: camera PWDN, active-high power-down.
REQ-013 SHALL have port o_resetb, output, 1 bit: camera RESETB, active-low.
REQ-014 SHALL have port o_xclk_en, output, 1 bit: enables the camera XCLK driver.
REQ-015 SHALL have port o_start_init, output, 1 bit: one-cycle pulse to sccb_top i_start_init.
REQ-016 SHALL have port o_ready, output, 1 bit: camera powered and configured.
REQ-017 SHALL have port o_fault, output, 1 bit: retries exhausted or timeout budget spent.
REQ-018 SHALL have port o_retry_cnt, output, 2 bits: failures seen since the last reset or restart.

Function
REQ-019 SHALL implement the states PWR_WAIT, PWDN_REL, RST_REL, START, WAIT_DONE, READY and FAULT.
REQ-020 SHALL define the wait length for each time parameter as N = T_x_US*CLK_FREQ/1_000_000 cycles, computed at elaboration.
REQ-021 SHALL size the cycle counter as $clog2 of the largest N plus 1, and SHALL clear it on every state change.
REQ-022 SHALL hold PWR_WAIT for N_PWR cycles with o_pwdn=1, o_resetb=0 and o_xclk_en=1, then enter PWDN_REL.
REQ-023 SHALL hold PWDN_REL for N_RST cycles with o_pwdn=0 and o_resetb=0, then enter RST_REL.
REQ-024 SHALL hold RST_REL for N_SCCB cycles with o_resetb=1, then enter START.
REQ-025 SHALL pulse o_start_init high for exactly one cycle in START, then enter WAIT_DONE.
REQ-026 SHALL go from WAIT_DONE to READY on i_init_done=1.
REQ-027 SHALL treat i_init_err=1, or N_INIT_TO elapsing in WAIT_DONE, as a failure, and SHALL increment the retry count on it.
REQ-028 SHALL, on a failure with retry count < MAX_RETRY, re-enter PWR_WAIT with o_pwdn=1 and o_resetb=0, giving a full power cycle.
REQ-029 SHALL, on a failure with retry count = MAX_RETRY, enter FAULT with o_fault=1, o_pwdn=1, o_resetb=0 and o_xclk_en=0.
REQ-030 SHALL let i_init_err win when i_init_done and i_init_err are high in the same cycle.
REQ-031 SHALL hold READY and FAULT until i_restart or reset, and SHALL drive o_ready=1 only in READY.
REQ-032 SHALL, on i_restart in any state, enter PWR_WAIT on the next edge, clear the counter and retry count, and force o_pwdn=1 and o_resetb=0.
REQ-033 SHALL ignore i_init_done and i_init_err outside WAIT_DONE.
REQ-034 SHALL register all outputs, so each output changes on the same edge as its state transition.
REQ-035 SHALL saturate o_retry_cnt at 3.

Reset
REQ-036 SHALL, while i_rst_n=0, force state=PWR_WAIT, counter=0, retry count=0, o_pwdn=1, o_resetb=0, o_xclk_en=0, o_start_init=0, o_ready=0 and o_fault=0.
REQ-037 SHALL raise o_xclk_en on the first edge after reset release, with the PWR_WAIT count starting on that same edge.
REQ-038 SHALL, on reset mid-sequence, abort the sequence immediately with no o_start_init pulse.

Structure
REQ-039 SHALL take the state encoding localparams and the us-to-cycle conversion function from the shared package ov5642_pkg, which sccb_top and sccb_core also use.
REQ-040 SHALL instantiate one sub-module, pwr_seq_timer, a loadable down-counter with a zero flag, for every wait.
REQ-041 SHALL be instantiated upstream of sccb_top, with o_start_init wired to i_start_init, i_init_done wired to o_done_led, and i_init_err wired to o_err_led.

Verification (bench: CLK_FREQ=1_000_000, T_PWR_US=10, T_RST_US=5, T_SCCB_US=20, T_INIT_TO_US=50, MAX_RETRY=2)
REQ-042 SHALL check nominal power-up: release reset; o_pwdn falls at edge 10, o_resetb rises at edge 15, o_start_init is high at edge 35 only; i_init_done at 40 gives o_ready=1 at 41.
REQ-043 SHALL check retry: i_init_err in the first WAIT_DONE gives o_pwdn=1, o_retry_cnt=1, and a second o_start_init exactly 35 cycles later.
REQ-044 SHALL check fault: three consecutive i_init_err results give o_fault=1, o_xclk_en=0 and o_retry_cnt=2, with no further o_start_init.
REQ-045 SHALL check timeout: with no done and no err, FAULT is reached after 3x(35+50) cycles.
REQ-046 SHALL check collisions: i_init_done and i_init_err high in the same cycle count as a retry; i_restart in FAULT clears o_fault and o_retry_cnt and restarts the power-up sequence.
REQ-047 SHALL check reset mid-sequence: i_rst_n=0 during RST_REL gives immediate o_resetb=0 and o_pwdn=1; after release the full 35-cycle sequence repeats.

Source files
------------

// File: rtl/ov5642_pkg.sv
// ov5642_pkg: shared definitions for the OV5642 camera bring-up blocks.
//   pwr_state_e   - power-sequencer state encoding
//   us_to_cycles  - converts a time in microseconds to clock cycles at clk_hz
//   max3          - largest of three cycle counts, used to size the wait counter
package ov5642_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_PWDN_REL,
    ST_RST_REL,
    ST_START,
    ST_WAIT_DONE,
    ST_READY,
    ST_FAULT
  } pwr_state_e;

  function automatic longint unsigned us_to_cycles(input longint unsigned t_us,
                                                   input longint unsigned clk_hz);
    return (t_us * clk_hz) / 64'd1_000_000;
  endfunction

  function automatic longint unsigned max3(input longint unsigned a,
                                           input longint unsigned b,
                                           input longint unsigned c);
    longint unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// pwr_seq_timer: loadable down-counter with a zero flag.
//   i_clk, i_rst_n  - clock, asynchronous active-low reset (count cleared)
//   i_load          - load i_load_val this cycle (takes priority over counting)
//   i_load_val      - value to load
//   o_zero          - counter is zero; the counter holds at zero
module pwr_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ov5642_pwr_seq.sv
// ov5642_pwr_seq: OV5642 power-up / reset sequencer with SCCB init supervision.
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_restart        - one-cycle pulse: re-run the full sequence, clear retries
//   i_init_done      - SCCB init finished and verified (level)
//   i_init_err       - SCCB init failed (level)
//   o_pwdn           - camera PWDN (active-high power-down)
//   o_resetb         - camera RESETB (active-low)
//   o_xclk_en        - camera XCLK driver enable
//   o_start_init     - one-cycle pulse starting SCCB init
//   o_ready          - camera powered and configured
//   o_fault          - retries exhausted
//   o_retry_cnt      - failures since last reset/restart
module ov5642_pwr_seq
  import ov5642_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned T_PWR_US     = 5000,
  parameter int unsigned T_RST_US     = 1000,
  parameter int unsigned T_SCCB_US    = 20000,
  parameter int unsigned T_INIT_TO_US = 500000,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_restart,
  input  logic       i_init_done,
  input  logic       i_init_err,
  output logic       o_pwdn,
  output logic       o_resetb,
  output logic       o_xclk_en,
  output logic       o_start_init,
  output logic       o_ready,
  output logic       o_fault,
  output logic [1:0] o_retry_cnt
);

  localparam longint unsigned N_PWR  = us_to_cycles(64'(T_PWR_US), 64'(CLK_FREQ));
  localparam longint unsigned N_RST  = us_to_cycles(64'(T_RST_US), 64'(CLK_FREQ));
  localparam longint unsigned N_SCCB = us_to_cycles(64'(T_SCCB_US), 64'(CLK_FREQ));
  localparam longint unsigned N_INIT = us_to_cycles(64'(T_INIT_TO_US), 64'(CLK_FREQ));
  localparam int unsigned     CW     = $clog2(max3(max3(N_PWR, N_RST, N_SCCB), N_INIT, 64'd1)) + 1;

  // A state of N cycles loads N-1 on entry and leaves on the edge that sees zero.
  localparam logic [CW-1:0] LD_PWR  = CW'((N_PWR  >= 64'd1) ? N_PWR  - 64'd1 : 64'd0);
  localparam logic [CW-1:0] LD_RST  = CW'((N_RST  >= 64'd1) ? N_RST  - 64'd1 : 64'd0);
  localparam logic [CW-1:0] LD_SCCB = CW'((N_SCCB >= 64'd1) ? N_SCCB - 64'd1 : 64'd0);
  // The first edge after reset is itself the first PWR_WAIT cycle, so one less.
  localparam logic [CW-1:0] LD_PWR1 = CW'((N_PWR  >= 64'd2) ? N_PWR  - 64'd2 : 64'd0);
  // Timeout runs from the o_start_init edge; the START cycle counts toward it.
  localparam logic [CW-1:0] LD_INIT = CW'((N_INIT >= 64'd2) ? N_INIT - 64'd2 : 64'd0);
  localparam logic [1:0]    RETRY_LIM = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);

  pwr_state_e    r_state, w_state_nxt;
  logic          r_started;
  logic [1:0]    r_retry, w_retry_nxt;
  logic          w_load, w_zero, w_fail;
  logic [CW-1:0] w_load_val;
  logic          w_pwdn, w_resetb, w_xclk_en, w_start_init, w_ready, w_fault;
  logic          r_pwdn, r_resetb, r_xclk_en, r_start_init, r_ready, r_fault;

  pwr_seq_timer #(.W(CW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_fail      = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    if (i_restart) begin
      w_state_nxt = ST_PWR_WAIT;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_PWR_WAIT: begin
          if (!r_started) begin
            if (N_PWR <= 64'd1) w_state_nxt = ST_PWDN_REL;
          end else if (w_zero) begin
            w_state_nxt = ST_PWDN_REL;
          end
        end
        ST_PWDN_REL:  if (w_zero) w_state_nxt = ST_RST_REL;
        ST_RST_REL:   if (w_zero) w_state_nxt = ST_START;
        ST_START:     w_state_nxt = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (i_init_err)       w_fail = 1'b1;
          else if (i_init_done) w_state_nxt = ST_READY;
          else if (w_zero)      w_fail = 1'b1;
        end
        default: ;
      endcase
      if (w_fail) begin
        if (r_retry >= RETRY_LIM) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_state_nxt = ST_PWR_WAIT;
          w_retry_nxt = (r_retry == 2'd3) ? 2'd3 : r_retry + 2'd1;
        end
      end
    end

    if (i_restart || (w_state_nxt != r_state)) begin
      w_load = 1'b1;
      case (w_state_nxt)
        ST_PWR_WAIT:  w_load_val = LD_PWR;
        ST_PWDN_REL:  w_load_val = LD_RST;
        ST_RST_REL:   w_load_val = LD_SCCB;
        ST_WAIT_DONE: w_load_val = LD_INIT;
        default:      w_load_val = '0;
      endcase
    end else if (!r_started) begin
      w_load     = 1'b1;
      w_load_val = LD_PWR1;
    end
  end

  // Outputs decoded from the next state and registered with it.
  always_comb begin
    w_pwdn       = 1'b0;
    w_resetb     = 1'b1;
    w_xclk_en    = 1'b1;
    w_start_init = 1'b0;
    w_ready      = 1'b0;
    w_fault      = 1'b0;
    case (w_state_nxt)
      ST_PWR_WAIT: begin w_pwdn = 1'b1; w_resetb = 1'b0; end
      ST_PWDN_REL: w_resetb = 1'b0;
      ST_START:    w_start_init = 1'b1;
      ST_READY:    w_ready = 1'b1;
      ST_FAULT: begin
        w_pwdn    = 1'b1;
        w_resetb  = 1'b0;
        w_xclk_en = 1'b0;
        w_fault   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_PWR_WAIT;
      r_started    <= 1'b0;
      r_retry      <= '0;
      r_pwdn       <= 1'b1;
      r_resetb     <= 1'b0;
      r_xclk_en    <= 1'b0;
      r_start_init <= 1'b0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_started    <= 1'b1;
      r_retry      <= w_retry_nxt;
      r_pwdn       <= w_pwdn;
      r_resetb     <= w_resetb;
      r_xclk_en    <= w_xclk_en;
      r_start_init <= w_start_init;
      r_ready      <= w_ready;
      r_fault      <= w_fault;
    end
  end

  assign o_pwdn       = r_pwdn;
  assign o_resetb     = r_resetb;
  assign o_xclk_en    = r_xclk_en;
  assign o_start_init = r_start_init;
  assign o_ready      = r_ready;
  assign o_fault      = r_fault;
  assign o_retry_cnt  = r_retry;

endmodule
